// File: rtl/arlet6502_bus_arbiter.sv
// Memory-cycle arbiter between the arlet6502 core and a DMA/loader port on one synchronous RAM.
// Optional ARB_STALL_CNT_EN adds a saturating count of CPU stall cycles on output stall_cnt.
module arlet6502_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_CPU, S_DMA, S_RESTORE} state_t;

  state_t            state_q, state_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic              cpu_rd_q, cpu_rd_d;

  always_comb begin
    mem_a     = cpu_a;
    mem_wdata = cpu_do;
    mem_we    = cpu_we;
    case (state_q)
      S_DMA: begin
        mem_a     = dma_a;
        mem_wdata = dma_wdata;
        mem_we    = dma_req & dma_we;
      end
      S_RESTORE: mem_we = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CPU: begin
        // The core ignores rdy during writes, so a grant waits for a read cycle.
        if (dma_req && !cpu_we && cpu_rdy_q) begin
          state_d = S_DMA;
          cnt_d   = '0;
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          state_d = S_RESTORE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MAX_BURST)) state_d = S_RESTORE;
        end
      end
      default: state_d = S_CPU;
    endcase
  end

  always_comb begin
    cpu_rdy_d    = (state_d == S_CPU);
    dma_gnt_d    = (state_d == S_DMA);
    cpu_rd_d     = ((state_q == S_CPU) && !cpu_we) || (state_q == S_RESTORE);
    dma_rvalid_d = (state_q == S_DMA) && dma_req && !dma_we;
    held_d       = cpu_rd_q ? mem_rdata : held_q;
    dma_rdata_d  = dma_rvalid_q ? mem_rdata : dma_rdata_q;
  end

  // Read data is live from the RAM in the cycle after a read, otherwise the captured copy.
  assign cpu_di     = cpu_rd_q ? mem_rdata : held_q;
  assign dma_rdata  = dma_rvalid_q ? mem_rdata : dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdy    = cpu_rdy_q;
  assign dma_gnt    = dma_gnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CPU;
      cpu_rdy_q    <= 1'b1;
      dma_gnt_q    <= 1'b0;
      cnt_q        <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      held_q       <= DATA_W'(8'hEA);
      cpu_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_gnt_q    <= dma_gnt_d;
      cnt_q        <= cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      held_q       <= held_d;
      cpu_rd_q     <= cpu_rd_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!cpu_rdy_q && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
